// File: rtl/router_fifo.sv
// Packet FIFO for one router output port: 16 words of {header flag, byte}.
// It also tracks how many bytes of the current packet remain to be read.
module router_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       soft_reset,
   input  logic       write_enb,
   input  logic       read_enb,
   input  logic       lfd_state,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [6:0]       r_pkt_cnt;
   logic [7:0]       r_data_out;

   logic             w_full;
   logic             w_empty;
   logic             w_wr;
   logic             w_rd;
   logic [WIDTH-1:0] w_rd_word;

   // The pointers carry one extra wrap bit so full and empty can be told apart.
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_wr      = write_enb && !w_full;
   assign w_rd      = read_enb && !w_empty;
   assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pkt_cnt  <= '0;
         r_data_out <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_data_out <= w_rd_word[7:0];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            // A header byte's upper six bits hold the payload length; add one for parity.
            if (w_rd_word[WIDTH-1])
               r_pkt_cnt <= {1'b0, w_rd_word[7:2]} + 7'd1;
            else if (r_pkt_cnt != 7'd0)
               r_pkt_cnt <= r_pkt_cnt - 7'd1;
         end else if (r_pkt_cnt == 7'd0) begin
            r_data_out <= 8'h00;
         end
      end
   end

   assign data_out = r_data_out;
   assign full     = w_full;
   assign empty    = w_empty;

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed vector table, corner-case
// sequences and random traffic checked against a queue-based packet model.
module tb_router_fifo;

   logic       clock = 1'b0;
   logic       resetn, soft_reset, write_enb, read_enb, lfd_state;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full, empty;

   router_fifo dut (
      .clock      (clock),
      .resetn     (resetn),
      .soft_reset (soft_reset),
      .write_enb  (write_enb),
      .read_enb   (read_enb),
      .lfd_state  (lfd_state),
      .data_in    (data_in),
      .data_out   (data_out),
      .full       (full),
      .empty      (empty)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of stored words plus the remaining-byte count.
   logic [8:0] m_q[$];
   int         m_cnt  = 0;
   logic [7:0] m_dout = 8'h00;

   typedef struct {
      logic       rn, sr, we, re, lfd;
      logic [7:0] din;
      logic [7:0] e_dout;
      logic       e_full, e_empty;
      int         e_cnt;
   } vec_t;
   vec_t vecs[13];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [8:0] w;
      bit rd, wr;
      if (!resetn || soft_reset) begin
         m_q.delete();
         m_cnt  = 0;
         m_dout = 8'h00;
      end else begin
         rd = read_enb && (m_q.size() > 0);
         wr = write_enb && (m_q.size() < 16);
         if (rd) begin
            w      = m_q.pop_front();
            m_dout = w[7:0];
            if (w[8])           m_cnt = int'(w[7:2]) + 1;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
         end else if (m_cnt == 0) begin
            m_dout = 8'h00;
         end
         if (wr) m_q.push_back({lfd_state, data_in});
      end
   endtask

   task automatic cyc(input logic a_rn, input logic a_sr, input logic a_we,
                      input logic a_re, input logic a_lfd, input logic [7:0] a_din);
      @(negedge clock);
      resetn = a_rn; soft_reset = a_sr; write_enb = a_we;
      read_enb = a_re; lfd_state = a_lfd; data_in = a_din;
      @(posedge clock);
      model_step();
      #1;
      chk("model_dout",  int'(data_out), int'(m_dout));
      chk("model_full",  int'(full),  int'(m_q.size() == 16));
      chk("model_empty", int'(empty), int'(m_q.size() == 0));
      chk("model_cnt",   int'(dut.r_pkt_cnt), m_cnt);
   endtask

   initial begin
      resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
      read_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;

      // rn sr we re lfd din | dout full empty cnt
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,1'b1,0};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,1'b1,0};
      vecs[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b1,8'h0D, 8'h00,1'b0,1'b0,0};
      vecs[3]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h11, 8'h00,1'b0,1'b0,0};
      vecs[4]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h22, 8'h00,1'b0,1'b0,0};
      vecs[5]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h33, 8'h00,1'b0,1'b0,0};
      vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,8'h3C, 8'h00,1'b0,1'b0,0};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h0D,1'b0,1'b0,4};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h11,1'b0,1'b0,3};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h22,1'b0,1'b0,2};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h33,1'b0,1'b0,1};
      vecs[11] = '{1'b1,1'b0,1'b0,1'b1,1'b0,8'h00, 8'h3C,1'b0,1'b1,0};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,8'h00, 8'h00,1'b0,1'b1,0};

      foreach (vecs[i]) begin
         cyc(vecs[i].rn, vecs[i].sr, vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
         chk("vec_dout",  int'(data_out), int'(vecs[i].e_dout));
         chk("vec_full",  int'(full),  int'(vecs[i].e_full));
         chk("vec_empty", int'(empty), int'(vecs[i].e_empty));
         chk("vec_cnt",   int'(dut.r_pkt_cnt), vecs[i].e_cnt);
      end

      // Fill to 16, 17th write dropped, then drain in order.
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00);
      for (int i = 0; i <= 16; i++) begin
         cyc(1'b1,1'b0,1'b1,1'b0,1'b0,8'(i));
         if (i >= 15) chk("full_after_16", int'(full), 1);
      end
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
         chk("drain_order", int'(data_out), i);
      end
      chk("drain_empty", int'(empty), 1);

      // Read and write together while full: only the read happens.
      for (int i = 0; i < 16; i++) cyc(1'b1,1'b0,1'b1,1'b0,1'b0,8'hA0 + 8'(i));
      cyc(1'b1,1'b0,1'b1,1'b1,1'b0,8'h55);
      chk("full_rw_dout", int'(data_out), 8'hA0);
      chk("full_rw_full", int'(full), 0);
      for (int i = 1; i < 16; i++) begin
         cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
         chk("full_rw_order", int'(data_out), 8'hA0 + i);
      end
      chk("full_rw_empty", int'(empty), 1);

      // Soft reset mid-packet, overriding a same-cycle write.
      cyc(1'b1,1'b0,1'b1,1'b0,1'b1,8'h0D);
      cyc(1'b1,1'b0,1'b1,1'b0,1'b0,8'h11);
      cyc(1'b1,1'b0,1'b1,1'b1,1'b0,8'h22);
      cyc(1'b1,1'b1,1'b1,1'b1,1'b0,8'h33);
      chk("soft_empty", int'(empty), 1);
      chk("soft_dout",  int'(data_out), 0);
      chk("soft_cnt",   int'(dut.r_pkt_cnt), 0);
      cyc(1'b1,1'b0,1'b1,1'b0,1'b1,8'h04);
      cyc(1'b1,1'b0,1'b1,1'b0,1'b0,8'hAA);
      cyc(1'b1,1'b0,1'b1,1'b0,1'b0,8'hAE);
      cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
      chk("fresh_hdr", int'(data_out), 8'h04);
      chk("fresh_cnt", int'(dut.r_pkt_cnt), 2);
      cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
      chk("fresh_pay", int'(data_out), 8'hAA);
      cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
      chk("fresh_par", int'(data_out), 8'hAE);

      // Read while empty holds data_out mid-packet; read+write while empty lands the write.
      cyc(1'b0,1'b0,1'b0,1'b0,1'b0,8'h00);
      cyc(1'b1,1'b0,1'b1,1'b0,1'b1,8'h0D);
      cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
      cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
      chk("empty_rd_dout",  int'(data_out), 8'h0D);
      chk("empty_rd_empty", int'(empty), 1);
      cyc(1'b1,1'b0,1'b1,1'b1,1'b0,8'h77);
      chk("empty_rw_empty", int'(empty), 0);
      chk("empty_rw_dout",  int'(data_out), 8'h0D);
      cyc(1'b1,1'b0,1'b0,1'b1,1'b0,8'h00);
      chk("empty_rw_word",  int'(data_out), 8'h77);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom % 200) != 0, ($urandom % 60) == 0, 1'($urandom),
             ($urandom % 3) != 0 ? 1'($urandom) : 1'b0,
             ($urandom % 6) == 0, 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
